floo_route_stage: RTL and testbench
===================================

Name: floo_route_stage

Overview:
- Parametrised XY route-computation pipeline stage for the mesh router input port; successor to the fixed 5-direction XY scheme.
- Adds optional ruche express links: directions RucheNorth = 5, RucheEast = 6, RucheSouth = 7, RucheWest = 8.
- Wormhole route locking: the head flit's route is held for every following flit of the packet.
- One registered stage with valid/ready handshake between input buffer and switch allocation.

Parameters:
- NumXBits, 3, width of X coordinate.
- NumYBits, 3, width of Y coordinate.
- RucheFactor, 0, hop length of ruche links. 0 disables ruche; otherwise must be ≥ 2.
- DataWidth, 64, flit payload width.
- NumRoutes, derived, 5 if RucheFactor == 0 else 9. Not user-overridable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- xy_id_x_i  in  NumXBits  local router X coordinate (quasi-static)
- xy_id_y_i  in  NumYBits  local router Y coordinate (quasi-static)
- valid_i  in  1  input flit valid
- ready_o  out  1  input flit accepted
- dst_x_i  in  NumXBits  destination X (sampled on head flits only)
- dst_y_i  in  NumYBits  destination Y (sampled on head flits only)
- last_i  in  1  last flit of packet
- data_i  in  DataWidth  flit payload
- valid_o  out  1  output flit valid
- ready_i  in  1  downstream ready
- data_o  out  DataWidth  registered payload
- last_o  out  1  registered last flag
- route_dir_o  out  4  direction code 0..8 (Eject = 0, North = 1, East = 2, South = 3, West = 4, ruche codes 5..8)
- route_sel_o  out  NumRoutes  one-hot of route_dir_o
- locked_o  out  1  mid-packet indicator (state == LOCKED)

Behaviour:
- Reset (synchronous, rst_i = 1 at a clock edge) forces:
  - valid_o = 0, data_o = 0, last_o = 0
  - route_dir_o = 0, route_sel_o = 1 (Eject), locked_o = 0
  - state = IDLE, stored route = Eject
- Reset mid-packet abandons the packet. The next accepted flit is treated as a head flit.
- Handshakes:
  - Transfer in on valid_i && ready_o; transfer out on valid_o && ready_i.
  - ready_o = !valid_o || ready_i, combinational from ready_i.
  - Full throughput of one flit per cycle; latency 1 cycle from input transfer to valid_o.
  - While valid_o && !ready_i, all outputs hold stable.
  - valid_o never drops without an output transfer (except on reset).
- Route computation, applied to head flits only:
  - dx = dst_x_i − xy_id_x_i and dy = dst_y_i − xy_id_y_i, both signed, width N+1 bits (no wrap).
  - X is resolved first.
  - If dx > 0: RucheEast if RucheFactor > 0 && dx ≥ RucheFactor, else East.
  - If dx < 0: RucheWest if RucheFactor > 0 && −dx ≥ RucheFactor, else West.
  - Else if dy > 0: RucheNorth / North, using the same threshold rule.
  - Else if dy < 0: RucheSouth / South, using the same threshold rule.
  - Else (dx == 0 && dy == 0): Eject.
- FSM, advancing only on an input transfer:
  - IDLE: flit is a head flit; route is computed.
    - last_i = 1: single-flit packet, stay in IDLE.
    - last_i = 0: store the route and go to LOCKED.
  - LOCKED: route = stored route; dst_x_i / dst_y_i are ignored.
    - last_i = 1: go to IDLE.
    - last_i = 0: stay in LOCKED.
- locked_o reflects the state after the update. It asserts the cycle after a non-last head flit is accepted.
- A stall at the output does not affect FSM state; no input transfer means no state change.
- Route output register loads with data_o on every input transfer.
- Changing xy_id_*_i mid-packet does not alter the locked route.

Test Plan:
1. Reset, RucheFactor = 0, local (2,2), single flit dst (5,1), ready_i = 1 → after 1 cycle valid_o = 1, route_dir_o = 2 (East), route_sel_o = 5'b00100, locked_o = 0.
2. RucheFactor = 3, local (4,4):
   - dst (0,4) → RucheWest (8)
   - dst (2,4) → West (4)
   - dst (4,7) → RucheNorth (5)
   - dst (4,4) → Eject (0), route_sel_o = 9'b000000001
3. 4-flit packet, head dst (1,2) from local (1,0), body flits carry garbage dst (7,7) → all four outputs route_dir_o = 1 (North). locked_o = 1 after flit 1, 0 after flit 4.
4. Backpressure: ready_i = 0 for 3 cycles with valid_o = 1 → data_o, route_dir_o and last_o stable; ready_o = 0; no input consumed. Release → back-to-back flits at 1/cycle.
5. Reset asserted after flit 2 of a 4-flit packet → valid_o = 0, locked_o = 0. Next flit dst (0,0) from local (1,1) routes West (4) as a fresh head.
6. Max-distance, NumXBits = 3: local (0,0), dst (7,0), RucheFactor = 2 → RucheEast (6). No overflow in the signed difference.

Source files
------------

// File: rtl/floo_route_stage.sv
// XY route-computation stage for a mesh router input port, with optional ruche
// express links and wormhole route locking behind a single valid/ready register.
module floo_route_stage #(
  parameter int NumXBits    = 3,
  parameter int NumYBits    = 3,
  parameter int RucheFactor = 0,
  parameter int DataWidth   = 64
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumXBits-1:0]                       xy_id_x_i,
  input  logic [NumYBits-1:0]                       xy_id_y_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  input  logic [NumXBits-1:0]                       dst_x_i,
  input  logic [NumYBits-1:0]                       dst_y_i,
  input  logic                                      last_i,
  input  logic [DataWidth-1:0]                      data_i,
  output logic                                      valid_o,
  input  logic                                      ready_i,
  output logic [DataWidth-1:0]                      data_o,
  output logic                                      last_o,
  output logic [3:0]                                route_dir_o,
  output logic [((RucheFactor == 0) ? 5 : 9)-1:0]   route_sel_o,
  output logic                                      locked_o
);

  localparam int NumRoutes = (RucheFactor == 0) ? 5 : 9;

  typedef enum logic [3:0] {
    DirEject      = 4'd0,
    DirNorth      = 4'd1,
    DirEast       = 4'd2,
    DirSouth      = 4'd3,
    DirWest       = 4'd4,
    DirRucheNorth = 4'd5,
    DirRucheEast  = 4'd6,
    DirRucheSouth = 4'd7,
    DirRucheWest  = 4'd8
  } route_dir_e;

  typedef enum logic {
    Idle,
    Locked
  } state_e;

  state_e     state;
  route_dir_e stored_route;
  route_dir_e route_q;
  route_dir_e head_route;
  route_dir_e route_next;

  logic signed [NumXBits:0] dx, adx;
  logic signed [NumYBits:0] dy, ady;
  logic dx_neg, dx_pos, dy_neg, dy_pos;
  logic in_fire;

  // A hop takes the express link only when ruche exists and the remaining
  // distance covers at least one full ruche hop.
  function automatic logic use_express(input int mag);
    return (RucheFactor > 0) && (mag >= RucheFactor);
  endfunction

  assign ready_o = !valid_o || ready_i;
  assign in_fire = valid_i && ready_o;

  // NOTE: every signal assigned in an always_comb block gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    // One extra bit keeps the coordinate differences from wrapping.
    dx     = $signed({1'b0, dst_x_i}) - $signed({1'b0, xy_id_x_i});
    dy     = $signed({1'b0, dst_y_i}) - $signed({1'b0, xy_id_y_i});
    dx_neg = dx[NumXBits];
    dy_neg = dy[NumYBits];
    dx_pos = !dx_neg && (dx != '0);
    dy_pos = !dy_neg && (dy != '0);
    adx    = dx_neg ? -dx : dx;
    ady    = dy_neg ? -dy : dy;

    head_route = DirEject;
    if (dx_pos)      head_route = use_express(int'(adx)) ? DirRucheEast  : DirEast;
    else if (dx_neg) head_route = use_express(int'(adx)) ? DirRucheWest  : DirWest;
    else if (dy_pos) head_route = use_express(int'(ady)) ? DirRucheNorth : DirNorth;
    else if (dy_neg) head_route = use_express(int'(ady)) ? DirRucheSouth : DirSouth;

    route_next = (state == Locked) ? stored_route : head_route;
  end

  always_comb begin
    route_sel_o = '0;
    for (int i = 0; i < NumRoutes; i++) begin
      route_sel_o[i] = (route_q == route_dir_e'(i));
    end
  end

  assign route_dir_o = route_q;
  assign locked_o    = (state == Locked);

  // NOTE: sequential state is written with non-blocking assignments only, so all
  // registers update together from values sampled at the same clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      last_o       <= 1'b0;
      route_q      <= DirEject;
      stored_route <= DirEject;
      state        <= Idle;
    end else if (in_fire) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      last_o  <= last_i;
      route_q <= route_next;
      case (state)
        Idle: begin
          if (!last_i) begin
            stored_route <= head_route;
            state        <= Locked;
          end
        end
        Locked: begin
          if (last_i) state <= Idle;
        end
        default: state <= Idle;
      endcase
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_floo_route_stage.sv
// Bench for floo_route_stage: three instances (RucheFactor 0, 3, 2) share
// stimulus and are compared against an arithmetic route model and pipeline model.
module tb_floo_route_stage;

  localparam int RF [3] = '{0, 3, 2};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  id_x, id_y, dst_x, dst_y;
  logic        valid_i, last_i, ready_i;
  logic [63:0] data_i;

  logic        v0, v1, v2, r0, r1, r2, l0, l1, l2, k0, k1, k2;
  logic [63:0] d0, d1, d2;
  logic [3:0]  dir0, dir1, dir2;
  logic [4:0]  sel0;
  logic [8:0]  sel1, sel2;

  logic        obs_valid [3];
  logic        obs_ready [3];
  logic        obs_last  [3];
  logic        obs_locked[3];
  logic [63:0] obs_data  [3];
  logic [3:0]  obs_dir   [3];
  logic [8:0]  obs_sel   [3];

  floo_route_stage #(.RucheFactor(0)) u_rf0 (
    .clk_i(clk), .rst_i(rst), .xy_id_x_i(id_x), .xy_id_y_i(id_y),
    .valid_i(valid_i), .ready_o(r0), .dst_x_i(dst_x), .dst_y_i(dst_y),
    .last_i(last_i), .data_i(data_i), .valid_o(v0), .ready_i(ready_i),
    .data_o(d0), .last_o(l0), .route_dir_o(dir0), .route_sel_o(sel0), .locked_o(k0));

  floo_route_stage #(.RucheFactor(3)) u_rf3 (
    .clk_i(clk), .rst_i(rst), .xy_id_x_i(id_x), .xy_id_y_i(id_y),
    .valid_i(valid_i), .ready_o(r1), .dst_x_i(dst_x), .dst_y_i(dst_y),
    .last_i(last_i), .data_i(data_i), .valid_o(v1), .ready_i(ready_i),
    .data_o(d1), .last_o(l1), .route_dir_o(dir1), .route_sel_o(sel1), .locked_o(k1));

  floo_route_stage #(.RucheFactor(2)) u_rf2 (
    .clk_i(clk), .rst_i(rst), .xy_id_x_i(id_x), .xy_id_y_i(id_y),
    .valid_i(valid_i), .ready_o(r2), .dst_x_i(dst_x), .dst_y_i(dst_y),
    .last_i(last_i), .data_i(data_i), .valid_o(v2), .ready_i(ready_i),
    .data_o(d2), .last_o(l2), .route_dir_o(dir2), .route_sel_o(sel2), .locked_o(k2));

  assign obs_valid[0] = v0;  assign obs_valid[1] = v1;  assign obs_valid[2] = v2;
  assign obs_ready[0] = r0;  assign obs_ready[1] = r1;  assign obs_ready[2] = r2;
  assign obs_last[0]  = l0;  assign obs_last[1]  = l1;  assign obs_last[2]  = l2;
  assign obs_locked[0] = k0; assign obs_locked[1] = k1; assign obs_locked[2] = k2;
  assign obs_data[0]  = d0;  assign obs_data[1]  = d1;  assign obs_data[2]  = d2;
  assign obs_dir[0]   = dir0; assign obs_dir[1]  = dir1; assign obs_dir[2]  = dir2;
  assign obs_sel[0]   = {4'b0, sel0}; assign obs_sel[1] = sel1; assign obs_sel[2] = sel2;

  // Reference model state: one output slot plus per-instance packet route.
  bit          m_valid, m_last, m_pkt;
  logic [63:0] m_data;
  int          m_dir [3];
  int          m_hold[3];
  bit          pre_ready[3];
  bit          exp_ready;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int ref_route(input int lx, ly, tx, ty, rf);
    int ddx, ddy;
    ddx = tx - lx;
    ddy = ty - ly;
    if (ddx > 0) return (rf > 0 && ddx >= rf) ? 6 : 2;
    if (ddx < 0) return (rf > 0 && -ddx >= rf) ? 8 : 4;
    if (ddy > 0) return (rf > 0 && ddy >= rf) ? 5 : 1;
    if (ddy < 0) return (rf > 0 && -ddy >= rf) ? 7 : 3;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 0; m_last = 0; m_pkt = 0; m_data = '0;
    for (int k = 0; k < 3; k++) begin m_dir[k] = 0; m_hold[k] = 0; end
  endtask

  // Drive one cycle of stimulus starting just after a rising edge, then
  // advance the model with the transfers that edge should perform.
  task automatic tick(input bit v, input int tx, ty, input bit l,
                      input logic [63:0] d, input bit r);
    bit fire;
    valid_i = v; dst_x = 3'(tx); dst_y = 3'(ty); last_i = l; data_i = d; ready_i = r;
    exp_ready = !m_valid || r;
    fire = v && exp_ready;
    @(negedge clk);
    for (int k = 0; k < 3; k++) pre_ready[k] = obs_ready[k];
    @(posedge clk); #1;
    if (fire) begin
      for (int k = 0; k < 3; k++) begin
        m_dir[k] = m_pkt ? m_hold[k] : ref_route(int'(id_x), int'(id_y), tx, ty, RF[k]);
        if (!m_pkt) m_hold[k] = m_dir[k];
      end
      m_pkt = !l; m_valid = 1; m_data = d; m_last = l;
    end else if (r) begin
      m_valid = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_valid[k] !== 1'b0 || obs_data[k] !== 64'd0 || obs_last[k] !== 1'b0 ||
          obs_dir[k] !== 4'd0 || obs_sel[k] !== 9'd1 || obs_locked[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst=%0d got v=%b d=%h l=%b dir=%0d sel=%b lk=%b, want all 0, sel=1",
                 k, obs_valid[k], obs_data[k], obs_last[k], obs_dir[k], obs_sel[k], obs_locked[k]);
      end
    end
  endtask

  task automatic test_routes();
    // local x, local y, dst x, dst y, instance, expected direction
    int tbl [6][6] = '{'{2,2,5,1,0,2}, '{4,4,0,4,1,8}, '{4,4,2,4,1,4},
                       '{4,4,4,7,1,5}, '{4,4,4,4,1,0}, '{0,0,7,0,2,6}};
    for (int i = 0; i < 6; i++) begin
      int k;
      k = tbl[i][4];
      id_x = 3'(tbl[i][0]); id_y = 3'(tbl[i][1]);
      tick(1, tbl[i][2], tbl[i][3], 1, 64'(i + 100), 1);
      n_tests++;
      if (obs_valid[k] !== 1'b1 || obs_dir[k] !== 4'(tbl[i][5]) ||
          obs_sel[k] !== (9'd1 << tbl[i][5]) || obs_locked[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL route case=%0d inst=%0d got v=%b dir=%0d sel=%b lk=%b, want v=1 dir=%0d lk=0",
                 i, k, obs_valid[k], obs_dir[k], obs_sel[k], obs_locked[k], tbl[i][5]);
      end
      for (int j = 0; j < 3; j++) begin
        n_tests++;
        if (obs_dir[j] !== 4'(m_dir[j]) || obs_data[j] !== m_data) begin
          n_fail++;
          $display("FAIL route_model case=%0d inst=%0d got dir=%0d d=%h, want dir=%0d d=%h",
                   i, j, obs_dir[j], obs_data[j], m_dir[j], m_data);
        end
      end
    end
  endtask

  task automatic test_wormhole();
    id_x = 3'd1; id_y = 3'd0;
    for (int f = 0; f < 4; f++) begin
      if (f == 2) begin id_x = 3'd6; id_y = 3'd6; end
      if (f == 0) tick(1, 1, 2, 0, 64'hA0, 1);
      else        tick(1, 7, 7, f == 3, 64'(160 + f), 1);
      n_tests++;
      if (obs_dir[0] !== 4'd1 || obs_locked[0] !== (f != 3) || obs_last[0] !== (f == 3)) begin
        n_fail++;
        $display("FAIL wormhole flit=%0d got dir=%0d lk=%b last=%b, want dir=1 lk=%b last=%b",
                 f, obs_dir[0], obs_locked[0], obs_last[0], f != 3, f == 3);
      end
      for (int k = 1; k < 3; k++) begin
        n_tests++;
        if (obs_dir[k] !== 4'(m_dir[k]) || obs_locked[k] !== m_pkt) begin
          n_fail++;
          $display("FAIL wormhole_model flit=%0d inst=%0d got dir=%0d lk=%b, want dir=%0d lk=%b",
                   f, k, obs_dir[k], obs_locked[k], m_dir[k], m_pkt);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    id_x = 3'd3; id_y = 3'd3;
    tick(1, 0, 3, 1, 64'hBEEF_0000, 1);
    for (int c = 0; c < 3; c++) begin
      tick(1, 6, 3, 1, 64'hBEEF_0001, 0);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (pre_ready[k] !== 1'b0 || obs_valid[k] !== 1'b1 || obs_data[k] !== 64'hBEEF_0000 ||
            obs_last[k] !== 1'b1 || obs_dir[k] !== 4'(ref_route(3, 3, 0, 3, RF[k]))) begin
          n_fail++;
          $display("FAIL stall cyc=%0d inst=%0d got rdy=%b v=%b d=%h l=%b dir=%0d, want rdy=0 v=1 d=beef0000 l=1",
                   c, k, pre_ready[k], obs_valid[k], obs_data[k], obs_last[k], obs_dir[k]);
        end
      end
    end
    for (int f = 1; f <= 4; f++) begin
      tick(1, 6, 3, 1, 64'hBEEF_0000 + 64'(f), 1);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (pre_ready[k] !== 1'b1 || obs_valid[k] !== 1'b1 ||
            obs_data[k] !== 64'hBEEF_0000 + 64'(f) ||
            obs_dir[k] !== 4'(ref_route(3, 3, 6, 3, RF[k]))) begin
          n_fail++;
          $display("FAIL b2b flit=%0d inst=%0d got rdy=%b v=%b d=%h dir=%0d, want rdy=1 v=1 d=%h",
                   f, k, pre_ready[k], obs_valid[k], obs_data[k], obs_dir[k], 64'hBEEF_0000 + 64'(f));
        end
      end
    end
    tick(0, 0, 0, 0, 64'd0, 1);
    n_tests++;
    if (obs_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain got v=%b want 0", obs_valid[0]);
    end
  endtask

  task automatic test_reset_mid_packet();
    id_x = 3'd1; id_y = 3'd1;
    tick(1, 3, 1, 0, 64'hC0, 1);
    tick(1, 5, 5, 0, 64'hC1, 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_valid[k] !== 1'b0 || obs_locked[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset inst=%0d got v=%b lk=%b, want 0 0", k, obs_valid[k], obs_locked[k]);
      end
    end
    tick(1, 0, 0, 1, 64'hC2, 1);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (obs_valid[k] !== 1'b1 || obs_dir[k] !== 4'd4 || obs_locked[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL fresh_head inst=%0d got v=%b dir=%0d lk=%b, want v=1 dir=4 lk=0",
                 k, obs_valid[k], obs_dir[k], obs_locked[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        id_x = 3'($urandom_range(0, 7)); id_y = 3'($urandom_range(0, 7));
      end
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 2) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (pre_ready[k] !== exp_ready || obs_valid[k] !== m_valid || obs_data[k] !== m_data ||
            obs_last[k] !== m_last || obs_dir[k] !== 4'(m_dir[k]) ||
            obs_sel[k] !== (9'd1 << m_dir[k]) || obs_locked[k] !== m_pkt) begin
          n_fail++;
          $display("FAIL random cyc=%0d inst=%0d got rdy=%b v=%b d=%h l=%b dir=%0d sel=%b lk=%b, want rdy=%b v=%b d=%h l=%b dir=%0d lk=%b",
                   c, k, pre_ready[k], obs_valid[k], obs_data[k], obs_last[k], obs_dir[k],
                   obs_sel[k], obs_locked[k], exp_ready, m_valid, m_data, m_last, m_dir[k], m_pkt);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; last_i = 1'b0;
    dst_x = '0; dst_y = '0; data_i = '0; id_x = '0; id_y = '0;
    test_reset();
    test_routes();
    test_wormhole();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
